// File: rtl/alu_sched_if.sv
// Request, ALU and result signals of the dual-lane ALU scheduler.
// The master side is decode/ALU/writeback; the slave side is the scheduler.
interface alu_sched_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_lane;
    logic [1:0]       in_op;
    logic             in_alt;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [1:0]       alu_op;
    logic             alu_alt;
    logic [31:0]      alu_d;
    logic [31:0]      alu2_a;
    logic [31:0]      alu2_b;
    logic [1:0]       alu2_op;
    logic             alu2_alt;
    logic [31:0]      alu2_d;

    logic             r0_valid;
    logic [31:0]      r0_data;
    logic [TAG_W-1:0] r0_tag;
    logic             r1_valid;
    logic [31:0]      r1_data;
    logic [TAG_W-1:0] r1_tag;
    logic             res_ready;

    modport master (
        output in_valid, in_lane, in_op, in_alt, in_a, in_b, in_tag,
        output alu_d, alu2_d, res_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_alt, alu2_a, alu2_b, alu2_op, alu2_alt,
        input  r0_valid, r0_data, r0_tag, r1_valid, r1_data, r1_tag
    );

    modport slave (
        input  in_valid, in_lane, in_op, in_alt, in_a, in_b, in_tag,
        input  alu_d, alu2_d, res_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_alt, alu2_a, alu2_b, alu2_op, alu2_alt,
        output r0_valid, r0_data, r0_tag, r1_valid, r1_data, r1_tag
    );
endinterface

// File: rtl/alu_sched.sv
// In-order issue queue feeding two ALU lanes, with registered issue stage and
// tagged per-lane result registers.
module alu_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    alu_sched_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic             lane;
        logic [1:0]       op;
        logic             alt;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    logic [1:0]       iss_valid_q;
    logic [31:0]      iss_a_q   [2];
    logic [31:0]      iss_b_q   [2];
    logic [1:0]       iss_op_q  [2];
    logic [1:0]       iss_alt_q;
    logic [TAG_W-1:0] iss_tag_q [2];

    logic [1:0]       res_valid_q;
    logic [31:0]      res_data_q [2];
    logic [TAG_W-1:0] res_tag_q  [2];

    logic             full, push, advance, pop0, pop1;
    logic [1:0]       pops;
    entry_t           head, nxt;
    logic [1:0]       sel_v;
    entry_t           sel_e [2];
    logic [31:0]      lane_d [2];

    assign full    = (count_q == CW'(DEPTH));
    assign push    = bus.in_valid && !full;
    assign advance = !(|res_valid_q) || bus.res_ready;
    assign head    = mem_q[rd_ptr_q];
    assign nxt     = mem_q[rd_ptr_q + PW'(1)];
    assign pop0    = advance && (count_q != '0);
    // The second entry may only ride along when it targets the other lane.
    assign pop1    = pop0 && (count_q >= CW'(2)) && (nxt.lane != head.lane);
    assign pops    = 2'(pop0) + 2'(pop1);
    assign count_d = count_q + CW'(push) - CW'(pops);

    always_comb begin
        sel_v[0] = (pop0 && !head.lane) || (pop1 && !nxt.lane);
        sel_v[1] = (pop0 && head.lane) || (pop1 && nxt.lane);
        sel_e[0] = head.lane ? nxt : head;
        sel_e[1] = head.lane ? head : nxt;
    end

    assign lane_d[0] = bus.alu_d;
    assign lane_d[1] = bus.alu2_d;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{lane: bus.in_lane, op: bus.in_op, alt: bus.in_alt,
                                 a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iss_valid_q <= '0;
            iss_alt_q   <= '0;
            res_valid_q <= '0;
            for (int l = 0; l < 2; l++) begin
                iss_a_q[l]    <= '0;
                iss_b_q[l]    <= '0;
                iss_op_q[l]   <= '0;
                iss_tag_q[l]  <= '0;
                res_data_q[l] <= '0;
                res_tag_q[l]  <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            rd_ptr_q <= rd_ptr_q + PW'(pops);
            count_q  <= count_d;
            if (advance) begin
                for (int l = 0; l < 2; l++) begin
                    res_valid_q[l] <= iss_valid_q[l];
                    res_data_q[l]  <= lane_d[l];
                    res_tag_q[l]   <= iss_tag_q[l];
                    iss_valid_q[l] <= sel_v[l];
                    // An idle lane keeps its last operands on the ALU ports.
                    if (sel_v[l]) begin
                        iss_a_q[l]   <= sel_e[l].a;
                        iss_b_q[l]   <= sel_e[l].b;
                        iss_op_q[l]  <= sel_e[l].op;
                        iss_alt_q[l] <= sel_e[l].alt;
                        iss_tag_q[l] <= sel_e[l].tag;
                    end
                end
            end
        end
    end

    assign bus.in_ready = !full;
    assign bus.alu_a    = iss_a_q[0];
    assign bus.alu_b    = iss_b_q[0];
    assign bus.alu_op   = iss_op_q[0];
    assign bus.alu_alt  = iss_alt_q[0];
    assign bus.alu2_a   = iss_a_q[1];
    assign bus.alu2_b   = iss_b_q[1];
    assign bus.alu2_op  = iss_op_q[1];
    assign bus.alu2_alt = iss_alt_q[1];
    assign bus.r0_valid = res_valid_q[0];
    assign bus.r0_data  = res_data_q[0];
    assign bus.r0_tag   = res_tag_q[0];
    assign bus.r1_valid = res_valid_q[1];
    assign bus.r1_data  = res_data_q[1];
    assign bus.r1_tag   = res_tag_q[1];
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural ALU, queue-based reference model, directed
// scenarios followed by randomized traffic with random resets.
module tb_alu_sched;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic             lane;
        logic [1:0]       op;
        logic             alt;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alu_sched_if #(.TAG_W(TAG_W)) bus ();

    alu_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic lane, input logic [1:0] op,
                                           input logic alt, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        if (!lane) begin
            case (op)
                2'd0:    r = alt ? a - b : a + b;
                2'd1:    r = a & b;
                2'd2:    r = a ^ b;
                default: r = a | b;
            endcase
        end else begin
            case (op)
                2'd0:    r = a << b[4:0];
                2'd1:    r = alt ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
                2'd2:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                default: r = b;
            endcase
        end
        return r;
    endfunction

    assign bus.alu_d  = alu_fn(1'b0, bus.alu_op, bus.alu_alt, bus.alu_a, bus.alu_b);
    assign bus.alu2_d = alu_fn(1'b1, bus.alu2_op, bus.alu2_alt, bus.alu2_a, bus.alu2_b);

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int seen [16];
    bit model_ok = 0;

    // Reference model: pending queue, per-lane issue slot, per-lane result slot.
    req_t             mq[$];
    bit               iv [2];
    req_t             ir [2];
    bit               rv [2];
    logic [31:0]      rd [2];
    logic [TAG_W-1:0] rt [2];

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic lane, input logic [1:0] op, input logic alt,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] tag);
        req_t r;
        r.lane = lane; r.op = op; r.alt = alt; r.a = a; r.b = b; r.tag = tag;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, TAG_W'($urandom_range(0, 15)));
    endfunction

    function automatic bit rr_of(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'(cyc & 1);
    endfunction

    function automatic bit model_empty();
        return mq.size() == 0 && !iv[0] && !iv[1] && !rv[0] && !rv[1];
    endfunction

    task automatic step(input bit rst_v, input bit vld, input req_t rq, input bit rr,
                        output bit acc);
        req_t h;
        bit   adv;
        rst_n         = rst_v;
        bus.in_valid  = vld;
        bus.in_lane   = rq.lane;
        bus.in_op     = rq.op;
        bus.in_alt    = rq.alt;
        bus.in_a      = rq.a;
        bus.in_b      = rq.b;
        bus.in_tag    = rq.tag;
        bus.res_ready = rr;
        acc = rst_v && vld && (mq.size() < DEPTH);
        if (model_ok) begin
            check_val("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            if (rst_v && rr && bus.r0_valid) seen[bus.r0_tag]++;
            if (rst_v && rr && bus.r1_valid) seen[bus.r1_tag]++;
        end
        if (!rst_v) begin
            mq.delete();
            for (int l = 0; l < 2; l++) begin
                iv[l] = 0; ir[l] = '0; rv[l] = 0; rd[l] = '0; rt[l] = '0;
            end
        end else begin
            adv = !(rv[0] || rv[1]) || rr;
            if (adv) begin
                for (int l = 0; l < 2; l++) begin
                    rv[l] = iv[l];
                    rd[l] = alu_fn(1'(l), ir[l].op, ir[l].alt, ir[l].a, ir[l].b);
                    rt[l] = ir[l].tag;
                    iv[l] = 0;
                end
                if (mq.size() >= 1) begin
                    h = mq.pop_front();
                    ir[h.lane] = h;
                    iv[h.lane] = 1;
                    if (mq.size() >= 1 && mq[0].lane != h.lane) begin
                        h = mq.pop_front();
                        ir[h.lane] = h;
                        iv[h.lane] = 1;
                    end
                end
            end
            if (acc) mq.push_back(rq);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_v) model_ok = 1;
        check_val("r0_valid", 32'(bus.r0_valid), 32'(rv[0]));
        check_val("r1_valid", 32'(bus.r1_valid), 32'(rv[1]));
        if (rv[0]) begin
            check_val("r0_data", bus.r0_data, rd[0]);
            check_val("r0_tag", 32'(bus.r0_tag), 32'(rt[0]));
        end
        if (rv[1]) begin
            check_val("r1_data", bus.r1_data, rd[1]);
            check_val("r1_tag", 32'(bus.r1_tag), 32'(rt[1]));
        end
        check_val("alu_a", bus.alu_a, ir[0].a);
        check_val("alu_b", bus.alu_b, ir[0].b);
        check_val("alu_op_alt", {29'b0, bus.alu_op, bus.alu_alt}, {29'b0, ir[0].op, ir[0].alt});
        check_val("alu2_a", bus.alu2_a, ir[1].a);
        check_val("alu2_b", bus.alu2_b, ir[1].b);
        check_val("alu2_op_alt", {29'b0, bus.alu2_op, bus.alu2_alt},
                  {29'b0, ir[1].op, ir[1].alt});
    endtask

    task automatic idle(input bit rr);
        bit acc;
        step(1'b1, 1'b0, '0, rr, acc);
    endtask

    task automatic offer(input req_t rq, input int mode);
        bit acc;
        acc = 0;
        for (int k = 0; k < 50 && !acc; k++) step(1'b1, 1'b1, rq, rr_of(mode), acc);
        if (!acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int mode);
        for (int k = 0; k < 80 && !model_empty(); k++) idle(rr_of(mode));
        check_val("drain_done", 32'(model_empty()), 1);
    endtask

    task automatic clear_seen();
        for (int t = 0; t < 16; t++) seen[t] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   acc;
        int   total;
        req_t r7;
        bus.in_valid = 0; bus.in_lane = 0; bus.in_op = 0; bus.in_alt = 0;
        bus.in_a = 0; bus.in_b = 0; bus.in_tag = 0; bus.res_ready = 0;
        clear_seen();

        step(1'b0, 1'b0, '0, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, acc);
        check_val("rst_in_ready", 32'(bus.in_ready), 1);
        check_val("rst_alu_a", bus.alu_a, 0);
        check_val("rst_alu2_b", bus.alu2_b, 0);
        check_val("rst_r_data", bus.r0_data | bus.r1_data, 0);

        // Single lane-0 add: result two edges after acceptance.
        offer(mk(1'b0, 2'd0, 1'b0, 32'd5, 32'd3, 4'd1), 1);
        idle(1'b1);
        idle(1'b1);
        check_val("t1_r0_valid", 32'(bus.r0_valid), 1);
        check_val("t1_r0_data", bus.r0_data, 8);
        check_val("t1_r0_tag", 32'(bus.r0_tag), 1);
        check_val("t1_r1_valid", 32'(bus.r1_valid), 0);

        // Dual issue: both queued behind a held result, then released together.
        idle(1'b0);
        offer(mk(1'b0, 2'd0, 1'b1, 32'd0, 32'd1, 4'd2), 0);
        offer(mk(1'b1, 2'd0, 1'b0, 32'd1, 32'd31, 4'd3), 0);
        check_val("t2_hold_tag", 32'(bus.r0_tag), 1);
        check_val("t2_hold_data", bus.r0_data, 8);
        idle(1'b1);
        idle(1'b1);
        check_val("t2_r0_valid", 32'(bus.r0_valid), 1);
        check_val("t2_r1_valid", 32'(bus.r1_valid), 1);
        check_val("t2_r0_data", bus.r0_data, 32'hFFFF_FFFF);
        check_val("t2_r1_data", bus.r1_data, 32'h8000_0000);

        // Same-lane signed compares serialize one per cycle.
        offer(mk(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'd4), 1);
        offer(mk(1'b1, 2'd1, 1'b1, 32'd0, 32'hFFFF_FFFF, 4'd5), 1);
        offer(mk(1'b1, 2'd1, 1'b1, 32'd5, 32'd5, 4'd6), 1);
        check_val("t3_tag4", 32'(bus.r1_tag), 4);
        check_val("t3_data4", bus.r1_data, 1);
        idle(1'b1);
        check_val("t3_tag5", 32'(bus.r1_tag), 5);
        check_val("t3_data5", bus.r1_data, 0);
        idle(1'b1);
        check_val("t3_tag6", 32'(bus.r1_tag), 6);
        check_val("t3_data6", bus.r1_data, 0);
        idle(1'b1);

        // Backpressure until the queue fills, then drain.
        clear_seen();
        r7 = mk(1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd7);
        offer(r7, 0);
        for (int t = 8; t < 13; t++) offer(mk(1'b0, 2'($urandom_range(0, 3)), 1'b0,
                                             $urandom, $urandom, TAG_W'(t)), 0);
        check_val("t4_full", 32'(bus.in_ready), 0);
        step(1'b1, 1'b1, mk(1'b0, 2'd3, 1'b0, 32'd1, 32'd2, 4'd13), 1'b0, acc);
        step(1'b1, 1'b1, mk(1'b0, 2'd3, 1'b0, 32'd1, 32'd2, 4'd13), 1'b0, acc);
        check_val("t4_still_full", 32'(bus.in_ready), 0);
        check_val("t4_held_valid", 32'(bus.r0_valid), 1);
        check_val("t4_held_tag", 32'(bus.r0_tag), 7);
        check_val("t4_held_data", bus.r0_data, alu_fn(1'b0, r7.op, r7.alt, r7.a, r7.b));
        offer(mk(1'b0, 2'd3, 1'b0, 32'd1, 32'd2, 4'd13), 1);
        drain(1);
        for (int t = 7; t < 14; t++) check_val($sformatf("t4_seen%0d", t), seen[t], 1);

        // Alternating lanes across the pointer wrap with toggling res_ready.
        clear_seen();
        for (int t = 0; t < 10; t++) begin
            offer(mk(1'(t & 1), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, TAG_W'(t)), 2);
        end
        drain(2);
        for (int t = 0; t < 10; t++) check_val($sformatf("t5_seen%0d", t), seen[t], 1);

        // Reset with work queued, issued and captured.
        for (int t = 1; t < 6; t++) offer(mk(1'(t & 1), 2'd0, 1'b0, 32'(t), 32'd1, TAG_W'(t)), 0);
        step(1'b0, 1'b0, '0, 1'b0, acc);
        check_val("t6_r0_valid", 32'(bus.r0_valid), 0);
        check_val("t6_r1_valid", 32'(bus.r1_valid), 0);
        check_val("t6_in_ready", 32'(bus.in_ready), 1);
        clear_seen();
        for (int k = 0; k < 6; k++) idle(1'b1);
        total = 0;
        for (int t = 0; t < 16; t++) total += seen[t];
        check_val("t6_no_stale", total, 0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0), rand_req(),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Issue scheduler for the dual-lane ALU. It buffers ALU operation requests in an in-order queue and issues up to two per cycle: lane 0 handles add/sub/and/xor/or, lane 1 handles shift-left/compare/shift-right/pass-b. Each issued operation is held in a registered issue stage that drives the ALU ports, and results are captured into tagged per-lane result registers. It sits between decode and writeback.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- TAG_W, 4: width of the request tag returned with each result.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept a request; equals !full.
- in_lane  in  1  lane select: 0 = lane 0, 1 = lane 1.
- in_op  in  2  operation code for the selected lane.
- in_alt  in  1  alternate flag: subtract on lane 0; signed compare or arithmetic shift on lane 1.
- in_a, in_b  in  32  operands.
- in_tag  in  TAG_W  request tag.
- alu_a, alu_b  out  32  lane 0 operands; registered.
- alu_op  out  2  lane 0 opcode; registered.
- alu_alt  out  1  lane 0 alternate flag; registered.
- alu_d  in  32  lane 0 combinational result.
- alu2_a, alu2_b  out  32  lane 1 operands; registered.
- alu2_op  out  2  lane 1 opcode; registered.
- alu2_alt  out  1  lane 1 alternate flag; registered.
- alu2_d  in  32  lane 1 combinational result.
- r0_valid, r1_valid  out  1  result valid, per lane.
- r0_data, r1_data  out  32  result value.
- r0_tag, r1_tag  out  TAG_W  tag of the result.
- res_ready  in  1  writeback accepts all valid results this cycle.

## Operation
- Queue: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap naturally) and count (log2 DEPTH + 1 bits).
  - Push when in_valid && in_ready.
  - count_next = count + push − pops, where pops ∈ {0,1,2}.
- advance = !(r0_valid || r1_valid) || res_ready. When advance is low, the queue does not pop, and the issue and result registers hold.
- Issue selection when advance is high:
  - Head entry H (count ≥ 1) issues to lane H.lane.
  - Entry H+1 also issues in the same cycle only if count ≥ 2 and its lane ≠ H.lane.
  - There is no reordering. An entry never issues ahead of an older entry.
  - Same-lane neighbours serialize one per cycle.
- Issue registers, per lane: valid, operands, op, alt, tag.
  - Loaded with the selected entry on advance.
  - A lane with nothing selected gets valid = 0. Its operand, op, and alt outputs hold their previous values.
- Result registers: on advance, rN_valid ← issue valid of lane N, rN_data ← alu_d / alu2_d, rN_tag ← issue tag.
- No ordering between lanes is guaranteed at writeback. Consumers use the tag.

## Timing
- Reset (rst_n = 0 at an edge) sets:
  - count = 0, wr_ptr = rd_ptr = 0, in_ready = 1.
  - All issue valids = 0 and all r*_valid = 0.
  - alu_a, alu_b, alu2_a, alu2_b = 0; alu_op = alu2_op = 0; alu_alt = alu2_alt = 0; r*_data = 0; r*_tag = 0.
- Reset asserted mid-operation discards all queued, issued, and captured operations. No result for them is ever produced.
- Latency, with an empty pipeline and res_ready = 1:
  - Request accepted at edge E.
  - Issue registers load at E+1.
  - rN_valid = 1 with the correct data from E+2 until E+3.
  - Throughput: 2 ops per cycle for alternating lanes, 1 per cycle for a single lane.
- A result is consumed at an edge where rN_valid && res_ready. Results held with res_ready = 0 stay stable: valid, data, and tag unchanged.
- Full queue (count = DEPTH): in_ready = 0. A pop in the same cycle does not raise in_ready until the next cycle.
- Empty queue: no issue, and the issue valids clear on advance.
- A push into an empty queue cannot issue in the same cycle, so there is no bypass.
- Pointer wrap: entry DEPTH−1 is followed by entry 0. Order is preserved across the wrap.

## Test plan
- Lane 0 add, a = 5, b = 3, op = 0, alt = 0, tag = 1, pushed at edge 0 → r0_valid = 1, r0_data = 8, r0_tag = 1 after edge 2. r1_valid stays 0.
- Dual issue: push lane 0 sub (0 − 1, tag 2), then lane 1 shift-left (1 << 31, op = 0, tag 3) → both issue at the same edge. r0_data = 0xFFFFFFFF and r1_data = 0x80000000 valid in the same cycle.
- Same-lane serialization: three lane 1 signed compares pushed back-to-back, tags 4, 5, 6, with (−1 < 0), (0 < −1), (5 < 5) → r1 results 1, 0, 0 on consecutive cycles in tag order 4, 5, 6.
- Backpressure and full: res_ready = 0, push 6 lane 0 ops with DEPTH = 4 → in_ready = 0 after the queue holds 4. The held r0 result stays stable. Raising res_ready drains every op in order with no loss or duplication.
- Wrap-around: stream 10 alternating-lane ops with res_ready toggling every cycle → all 10 tags appear exactly once, and per-lane order is preserved.
- Reset mid-operation: rst_n = 0 for one edge with 3 ops queued and 2 issued → all r*_valid = 0 and in_ready = 1 on the next cycle. No stale tags ever appear afterwards.
